// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: drains the two SDRAM read FIFOs in step with VGA pixel requests and unpacks RGB.
// Optional macro TEST_PATTERN_EN adds an 8-bar colour test pattern selected by pattern_sel.
module sdram_frame_reader #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          LOAD_CYCLES  = 4,
    parameter int          PRIME_CYCLES = 64,
    parameter logic [23:0] FILL_RGB     = 24'h000000
) (
    input  logic        clk_vga,
    input  logic        reset_n,
    input  logic        orequest,
    input  logic [12:0] col,
    input  logic [12:0] row,
    input  logic [15:0] rd1_data,
    input  logic [15:0] rd2_data,
    input  logic        rd1_empty,
    input  logic        rd2_empty,
    input  logic        clear_err,
    input  logic        pattern_sel,
    output logic        rd_en,
    output logic        rd_load,
    output logic [7:0]  ored,
    output logic [7:0]  ogreen,
    output logic [7:0]  oblue,
    output logic        pix_valid,
    output logic        underflow,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [18:0] FRAME_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [15:0] LOAD_END   = 16'(LOAD_CYCLES);
    localparam logic [15:0] PRIME_LAST = 16'(PRIME_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELOAD   = 2'd0,
        ST_PRIME    = 2'd1,
        ST_WAIT_SOF = 2'd2,
        ST_STREAM   = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] phase_cnt_r;
    logic [18:0] pix_cnt_r;
    logic        req_d1_r;
    logic        pop_d1_r;
    logic        sof_s;
    logic        empty_any_s;
    logic        stream_req_s;
    logic        misalign_s;
    logic        err_inc_s;
    logic        starve_s;
    logic [23:0] pixel_next_s;

    assign sof_s       = orequest & (row == 13'd0) & (col == 13'd0);
    assign empty_any_s = rd1_empty | rd2_empty;

    // Classify the current request: aligning SOF, in-frame pixel, or misaligned SOF.
    always_comb begin
        stream_req_s = 1'b0;
        misalign_s   = 1'b0;
        err_inc_s    = 1'b0;
        case (state_r)
            ST_PRIME: begin
                err_inc_s = sof_s;
            end
            ST_WAIT_SOF: begin
                stream_req_s = sof_s;
            end
            ST_STREAM: begin
                misalign_s   = sof_s & (pix_cnt_r != 19'd0);
                stream_req_s = orequest & ~misalign_s;
                err_inc_s    = misalign_s;
            end
            default: begin
                stream_req_s = 1'b0;
                misalign_s   = 1'b0;
                err_inc_s    = 1'b0;
            end
        endcase
    end

    // A starved pixel is never popped so both FIFOs stay word-aligned.
    assign rd_en    = stream_req_s & ~empty_any_s;
    assign starve_s = stream_req_s & empty_any_s;

    // Frame sequencer with its registered status outputs.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RELOAD;
            phase_cnt_r <= 16'd0;
            pix_cnt_r   <= 19'd0;
            rd_load     <= 1'b0;
            underflow   <= 1'b0;
            frame_cnt   <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            if (starve_s) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end

            if (err_inc_s) begin
                if (clear_err) begin
                    err_cnt <= 16'd1;
                end else if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end else if (clear_err) begin
                err_cnt <= 16'd0;
            end

            case (state_r)
                ST_RELOAD: begin
                    if (phase_cnt_r == LOAD_END) begin
                        rd_load     <= 1'b0;
                        phase_cnt_r <= 16'd0;
                        state_r     <= ST_PRIME;
                    end else begin
                        rd_load     <= 1'b1;
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                ST_PRIME: begin
                    rd_load <= 1'b0;
                    if (phase_cnt_r == PRIME_LAST) begin
                        phase_cnt_r <= 16'd0;
                        state_r     <= ST_WAIT_SOF;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                ST_WAIT_SOF: begin
                    rd_load <= 1'b0;
                    if (sof_s) begin
                        pix_cnt_r <= 19'd1;
                        state_r   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    rd_load <= 1'b0;
                    if (misalign_s) begin
                        pix_cnt_r   <= 19'd0;
                        phase_cnt_r <= 16'd0;
                        state_r     <= ST_RELOAD;
                    end else if (orequest) begin
                        if (pix_cnt_r == FRAME_LAST) begin
                            pix_cnt_r   <= 19'd0;
                            phase_cnt_r <= 16'd0;
                            frame_cnt   <= frame_cnt + 16'd1;
                            state_r     <= ST_RELOAD;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + 19'd1;
                        end
                    end
                end
                default: begin
                    rd_load     <= 1'b0;
                    phase_cnt_r <= 16'd0;
                    pix_cnt_r   <= 19'd0;
                    state_r     <= ST_RELOAD;
                end
            endcase
        end
    end

`ifdef TEST_PATTERN_EN
    localparam logic [12:0] BAR_W = 13'(H_ACTIVE / 8);
    logic [12:0] bar_idx_s;
    logic        pat_d1_r;
    logic [23:0] bar_d1_r;
    logic        unused_s;

    assign bar_idx_s = col / BAR_W;
    assign unused_s  = ^{rd2_data[7:0], bar_idx_s[12:3]};

    // Bar colour is captured with the request so it lines up with the FIFO data stage.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            pat_d1_r <= 1'b0;
            bar_d1_r <= 24'h000000;
        end else begin
            pat_d1_r <= pattern_sel;
            bar_d1_r <= {{8{bar_idx_s[2]}}, {8{bar_idx_s[1]}}, {8{bar_idx_s[0]}}};
        end
    end

    // Pick the colour for the pixel registered at the end of the data stage.
    always_comb begin
        if (req_d1_r && pat_d1_r) begin
            pixel_next_s = bar_d1_r;
        end else if (req_d1_r && pop_d1_r) begin
            pixel_next_s = {rd1_data, rd2_data[15:8]};
        end else begin
            pixel_next_s = FILL_RGB;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{rd2_data[7:0], pattern_sel};

    // Pick the colour for the pixel registered at the end of the data stage.
    always_comb begin
        if (req_d1_r && pop_d1_r) begin
            pixel_next_s = {rd1_data, rd2_data[15:8]};
        end else begin
            pixel_next_s = FILL_RGB;
        end
    end
`endif

    // Two-stage output pipeline: request/pop stage, then FIFO data into RGB.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            req_d1_r              <= 1'b0;
            pop_d1_r              <= 1'b0;
            pix_valid             <= 1'b0;
            {ored, ogreen, oblue} <= 24'h000000;
        end else begin
            req_d1_r              <= orequest;
            pop_d1_r              <= rd_en;
            pix_valid             <= req_d1_r;
            {ored, ogreen, oblue} <= pixel_next_s;
        end
    end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Self-checking bench for sdram_frame_reader: VGA-like scan stimulus, FIFO source model and a
// frame-level behavioural model of what each request must produce two cycles later.
module tb_sdram_frame_reader;

    localparam int H      = 32;
    localparam int V      = 4;
    localparam int HTOT   = 40;
    localparam int VTOT   = 6;
    localparam int LOADC  = 4;
    localparam int PRIMEC = 64;
    localparam int FRAME  = H * V;
    localparam int ARM    = LOADC + 1 + PRIMEC;
    localparam logic [23:0] FILL = 24'h000000;

    logic        clk_vga = 1'b0;
    logic        reset_n;
    logic        orequest;
    logic [12:0] col;
    logic [12:0] row;
    logic [15:0] rd1_data;
    logic [15:0] rd2_data;
    logic        rd1_empty;
    logic        rd2_empty;
    logic        clear_err;
    logic        pattern_sel;
    logic        rd_en;
    logic        rd_load;
    logic [7:0]  ored;
    logic [7:0]  ogreen;
    logic [7:0]  oblue;
    logic        pix_valid;
    logic        underflow;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    always #5 clk_vga = ~clk_vga;

    sdram_frame_reader #(
        .H_ACTIVE(H), .V_ACTIVE(V), .LOAD_CYCLES(LOADC), .PRIME_CYCLES(PRIMEC), .FILL_RGB(FILL)
    ) dut (
        .clk_vga(clk_vga), .reset_n(reset_n), .orequest(orequest), .col(col), .row(row),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_empty(rd1_empty), .rd2_empty(rd2_empty),
        .clear_err(clear_err), .pattern_sel(pattern_sel), .rd_en(rd_en), .rd_load(rd_load),
        .ored(ored), .ogreen(ogreen), .oblue(oblue), .pix_valid(pix_valid),
        .underflow(underflow), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int sx, sy;
    int k_empty, k_clear, k_jump, k_drop;
    bit force_rd2_empty, force_clear;
    int rd_en_count, rd_load_count, drv_pops;

    // model state: frame phase expressed as time since reload began, plus stream progress
    int  m_since, m_pix, m_pops, m_frames, m_errs;
    bit  m_stream, m_under;
    bit  pend_valid, pend_pat, pend_first;
    logic [23:0] pend_rgb;
    logic [12:0] pend_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word1(input int k);
        logic [31:0] h;
        h = 32'(k) * 32'd40503 + 32'd12345;
        return (k == 0) ? 16'hABCD : h[15:0];
    endfunction

    function automatic logic [7:0] word2hi(input int k);
        logic [31:0] h;
        h = 32'(k) * 32'd2654435 + 32'd99;
        return (k == 0) ? 8'hEF : h[15:8];
    endfunction

`ifdef TEST_PATTERN_EN
    function automatic logic [23:0] bar_rgb(input logic [12:0] c);
        int b;
        b = int'(c) / (H / 8);
        return {((b & 4) != 0) ? 8'hFF : 8'h00, ((b & 2) != 0) ? 8'hFF : 8'h00,
                ((b & 1) != 0) ? 8'hFF : 8'h00};
    endfunction
`endif

    task automatic model_reset();
        m_since = 0; m_pix = 0; m_frames = 0; m_errs = 0;
        m_stream = 1'b0; m_under = 1'b0;
        pend_valid = 1'b0; pend_pat = 1'b0; pend_first = 1'b0;
        pend_rgb = FILL; pend_col = 13'd0;
    endtask

    // One clock: predict rd_en, advance the model over the edge, compare registered outputs.
    task automatic tick();
        bit sof, emp, take, mis, exp_pop, dut_pop, in_prime, ev;
        logic [23:0] new_rgb;
        bit new_pat, new_first;
        logic [12:0] new_col;
        bit o_valid, o_pat, o_first;
        logic [23:0] o_rgb;
        logic [12:0] o_col;
        @(negedge clk_vga);
        sof = orequest && (row == 13'd0) && (col == 13'd0);
        emp = rd1_empty || rd2_empty;
        take = 1'b0;
        mis = 1'b0;
        in_prime = !m_stream && (m_since > LOADC) && (m_since < ARM);
        if (m_stream) begin
            mis  = sof && (m_pix != 0);
            take = orequest && !mis;
        end else if (m_since >= ARM) begin
            take = sof;
        end
        exp_pop = take && !emp;
        check("rd_en", 32'(rd_en), 32'(exp_pop));
        dut_pop = rd_en;
        if (rd_en) rd_en_count++;

        @(posedge clk_vga);
        new_rgb = FILL; new_pat = 1'b0; new_first = 1'b0; new_col = col;
        if (exp_pop) begin
            new_rgb   = {word1(m_pops), word2hi(m_pops)};
            new_first = (m_pops == 0);
            m_pops++;
        end
`ifdef TEST_PATTERN_EN
        if (orequest && pattern_sel) begin
            new_rgb = bar_rgb(col);
            new_pat = 1'b1;
        end
`endif
        if (take && emp) m_under = 1'b1;
        else if (clear_err) m_under = 1'b0;
        ev = mis || (in_prime && sof);
        if (ev) m_errs = clear_err ? 1 : ((m_errs < 65535) ? m_errs + 1 : 65535);
        else if (clear_err) m_errs = 0;
        if (m_stream) begin
            if (mis) begin
                m_stream = 1'b0; m_since = 0; m_pix = 0;
            end else if (orequest) begin
                m_pix++;
                if (m_pix == FRAME) begin
                    m_pix = 0; m_frames = (m_frames + 1) & 16'hFFFF;
                    m_stream = 1'b0; m_since = 0;
                end
            end
        end else if (take) begin
            m_stream = 1'b1; m_pix = 1;
        end else if (m_since < ARM) begin
            m_since++;
        end
        o_valid = pend_valid; o_rgb = pend_rgb; o_pat = pend_pat; o_col = pend_col; o_first = pend_first;
        pend_valid = orequest; pend_rgb = new_rgb; pend_pat = new_pat; pend_col = new_col;
        pend_first = new_first;

        #1;
        check("rd_load", 32'(rd_load), 32'(!m_stream && m_since >= 1 && m_since <= LOADC));
        check("pix_valid", 32'(pix_valid), 32'(o_valid));
        check("rgb", 32'({ored, ogreen, oblue}), 32'(o_rgb));
        check("underflow", 32'(underflow), 32'(m_under));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        check("err_cnt", 32'(err_cnt), 32'(m_errs));
        if (o_valid && o_first) check("first_pixel", 32'({ored, ogreen, oblue}), 32'h00ABCDEF);
`ifdef TEST_PATTERN_EN
        if (o_valid && o_pat && o_col == 13'd0) check("bar_col0", 32'({ored, ogreen, oblue}), 32'h000000);
        if (o_valid && o_pat && o_col == 13'(H / 8)) check("bar_col1", 32'({ored, ogreen, oblue}), 32'h0000FF);
        if (o_valid && o_pat && o_col == 13'(H - 1)) check("bar_last", 32'({ored, ogreen, oblue}), 32'hFFFFFF);
`endif
        if (rd_load) rd_load_count++;
        if (dut_pop) begin
            rd1_data = word1(drv_pops);
            rd2_data = {word2hi(drv_pops), 8'($urandom)};
            drv_pops++;
        end else begin
            rd1_data = 16'($urandom);
            rd2_data = 16'($urandom);
        end
    endtask

    task automatic drive_scan();
        bit drop;
        if (k_jump > 0 && $urandom_range(999, 0) < k_jump) begin
            sx = 0; sy = 0;
        end
        drop = (k_drop > 0) && ($urandom_range(99, 0) < k_drop);
        col = 13'(sx);
        row = 13'(sy);
        orequest = (sx < H) && (sy < V) && !drop;
        rd1_empty = 1'b0;
        rd2_empty = force_rd2_empty;
        if (k_empty > 0 && !(sx == 0 && sy == 0) && $urandom_range(99, 0) < k_empty) begin
            if ($urandom_range(1, 0) == 1) rd1_empty = 1'b1;
            else rd2_empty = 1'b1;
        end
        clear_err = force_clear || ((k_clear > 0) && ($urandom_range(99, 0) < k_clear));
        sx++;
        if (sx == HTOT) begin
            sx = 0; sy++;
            if (sy == VTOT) sy = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_scan();
            tick();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        orequest = 1'b0; col = 13'd0; row = 13'd0;
        rd1_empty = 1'b0; rd2_empty = 1'b0; clear_err = 1'b0;
        repeat (3) @(posedge clk_vga);
        #1;
        reset_n = 1'b1;
        model_reset();
        sx = 0; sy = 0;
    endtask

    initial begin
        reset_n = 1'b0; pattern_sel = 1'b0;
        rd1_data = 16'd0; rd2_data = 16'd0;
        k_empty = 0; k_clear = 0; k_jump = 0; k_drop = 0;
        force_rd2_empty = 1'b0; force_clear = 1'b0;
        drv_pops = 0; m_pops = 0;
        do_reset();

        // load pulse and no pops before the first accepted SOF
        rd_load_count = 0; rd_en_count = 0;
        run(240);
        check("load_pulse_len", 32'(rd_load_count), 32'd4);
        check("no_pop_before_sof", 32'(rd_en_count), 32'd0);

        // one clean frame
        rd_en_count = 0; rd_load_count = 0;
        run(240);
        check("frame_pops", 32'(rd_en_count), 32'(FRAME));
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        check("err_cnt_0", 32'(err_cnt), 32'd0);
        check("reload_after_frame", 32'(rd_load_count), 32'd4);

        // three starved requests mid-frame, then clear
        rd_en_count = 0;
        run(50);
        force_rd2_empty = 1'b1; run(3); force_rd2_empty = 1'b0;
        run(1);
        check("underflow_set", 32'(underflow), 32'd1);
        run(10);
        check("underflow_sticky", 32'(underflow), 32'd1);
        force_clear = 1'b1; run(1); force_clear = 1'b0;
        check("underflow_cleared", 32'(underflow), 32'd0);
        run(175);
        check("starved_frame_pops", 32'(rd_en_count), 32'(FRAME - 3));
        check("frame_cnt_2", 32'(frame_cnt), 32'd2);

        // SOF injected mid-frame
        run(50);
        sx = 0; sy = 0;
        run(240);
        check("misalign_err", 32'(err_cnt), 32'd1);
        check("misalign_no_frame", 32'(frame_cnt), 32'd2);
        run(240);
        check("recover_frame", 32'(frame_cnt), 32'd3);

        // randomized traffic
        k_empty = 10; k_clear = 3; k_jump = 2; k_drop = 2;
        run(4000);
        k_empty = 0; k_clear = 0; k_jump = 0; k_drop = 0;

        // asynchronous reset in the middle of streaming
        do_reset();
        run(540);
        check("pre_reset_frames", 32'(frame_cnt), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_load", 32'(rd_load), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_rgb", 32'({ored, ogreen, oblue}), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        do_reset();
        rd_load_count = 0;
        run(240);
        check("restart_load", 32'(rd_load_count), 32'd4);
        check("restart_frames_0", 32'(frame_cnt), 32'd0);
        run(240);
        check("restart_frames_1", 32'(frame_cnt), 32'd1);

`ifdef TEST_PATTERN_EN
        do_reset();
        pattern_sel = 1'b1;
        run(240);
        rd_en_count = 0;
        run(240);
        check("pattern_frame_pops", 32'(rd_en_count), 32'(FRAME));
        pattern_sel = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
